// File: rtl/wzorzec_detektor.sv
// Serial pattern detector: recovers step timing from edges on iDATA, samples mid-step,
// locks onto a repeating LEN-step pattern and keeps saturating good/bad frame counts.
module wzorzec_detektor #(
  parameter int unsigned    STEP_CYCLES = 5000000,
  parameter int unsigned    LEN         = 12,
  parameter logic [LEN-1:0] PATTERN     = 12'hE64,
  parameter int unsigned    MISS_MAX    = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iDATA,
  output logic       oLOCK,
  output logic       oMATCH,
  output logic       oTICK,
  output logic [7:0] oFRAMES,
  output logic [7:0] oERR
);

  localparam int unsigned PW = $clog2(STEP_CYCLES);
  localparam int unsigned FW = $clog2(LEN + 1);
  localparam int unsigned BW = $clog2(LEN);
  localparam int unsigned MW = $clog2(MISS_MAX + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_MID  = PW'(STEP_CYCLES / 2 - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(LEN);
  localparam logic [BW-1:0] BIT_LAST   = BW'(LEN - 1);
  localparam logic [MW-1:0] MISS_LIM   = MW'(MISS_MAX);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t         state;
  logic           s1, s2, s3;
  logic [PW-1:0]  phase;
  logic [LEN-1:0] shift;
  logic [FW-1:0]  fill;
  logic [BW-1:0]  bitCnt;
  logic [MW-1:0]  miss;

  logic           syncEdge;
  logic           tick;
  logic           hit;
  logic [LEN-1:0] shiftNext;
  logic [FW-1:0]  fillNext;
  logic [MW-1:0]  missNext;

  always_comb begin
    syncEdge  = s2 ^ s3;
    tick      = (phase == PHASE_MID);
    shiftNext = {shift[LEN-2:0], s2};
    fillNext  = (fill == FILL_FULL) ? fill : fill + FW'(1);
    hit       = (shiftNext == PATTERN);
    missNext  = miss + MW'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= HUNT;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      phase   <= '0;
      shift   <= '0;
      fill    <= '0;
      bitCnt  <= '0;
      miss    <= '0;
      oLOCK   <= 1'b0;
      oMATCH  <= 1'b0;
      oTICK   <= 1'b0;
      oFRAMES <= '0;
      oERR    <= '0;
    end else begin
      s1 <= iDATA;
      s2 <= s1;
      s3 <= s2;
      // An edge re-centres the sampling point even on a tick cycle; the tick still fires.
      if (syncEdge || phase == PHASE_LAST) phase <= '0;
      else                                 phase <= phase + PW'(1);

      oTICK  <= tick;
      oMATCH <= 1'b0;

      if (tick) begin
        shift <= shiftNext;
        fill  <= fillNext;
        unique case (state)
          HUNT: begin
            if (fillNext == FILL_FULL && hit) begin
              state  <= LOCKED;
              oLOCK  <= 1'b1;
              bitCnt <= '0;
              miss   <= '0;
              oMATCH <= 1'b1;
              if (oFRAMES != 8'hFF) oFRAMES <= oFRAMES + 8'd1;
            end
          end
          LOCKED: begin
            bitCnt <= (bitCnt == BIT_LAST) ? '0 : bitCnt + BW'(1);
            if (bitCnt == BIT_LAST) begin
              if (hit) begin
                oMATCH <= 1'b1;
                miss   <= '0;
                if (oFRAMES != 8'hFF) oFRAMES <= oFRAMES + 8'd1;
              end else begin
                if (oERR != 8'hFF) oERR <= oERR + 8'd1;
                // Shift and fill are kept so HUNT can re-lock on the very next tick.
                if (missNext == MISS_LIM) begin
                  state <= HUNT;
                  oLOCK <= 1'b0;
                  miss  <= '0;
                end else begin
                  miss <= missNext;
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wzorzec_detektor.sv
// Directed bench for wzorzec_detektor with 8-cycle steps and a 2-frame miss limit.
module tb_wzorzec_detektor;

  localparam logic [11:0] PAT = 12'hE64;
  localparam logic [11:0] BAD = 12'hE24;  // step 5 inverted

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iDATA;
  logic       oLOCK, oMATCH, oTICK;
  logic [7:0] oFRAMES, oERR;

  int nTotal = 0;
  int nBad   = 0;
  int cyc = 0, lastTick = 0, tickGap = 0, tickCnt = 0;
  int lastMatch = 0, matchGap = 0, matchCnt = 0;
  int jit [12] = '{10, 6, 10, 6, 10, 10, 6, 6, 10, 10, 6, 10};
  int t0, m0;

  wzorzec_detektor #(
    .STEP_CYCLES(8),
    .LEN        (12),
    .PATTERN    (PAT),
    .MISS_MAX   (2)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iDATA  (iDATA),
    .oLOCK  (oLOCK),
    .oMATCH (oMATCH),
    .oTICK  (oTICK),
    .oFRAMES(oFRAMES),
    .oERR   (oERR)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    #1;
    cyc++;
    if (oTICK) begin
      tickGap  = cyc - lastTick;
      lastTick = cyc;
      tickCnt++;
    end
    if (oMATCH) begin
      matchGap  = cyc - lastMatch;
      lastMatch = cyc;
      matchCnt++;
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    nTotal++;
    if (got != want) begin
      nBad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic sendBits(input logic [11:0] pat, input int first, input int last, input int len);
    for (int i = first; i <= last; i++) begin
      iDATA = pat[11-i];
      repeat (len) @(negedge iCLK);
    end
  endtask

  task automatic sendJit(input logic [11:0] pat);
    for (int i = 0; i < 12; i++) begin
      iDATA = pat[11-i];
      repeat (jit[i]) @(negedge iCLK);
    end
  endtask

  task automatic waitTick();
    int n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (!oTICK && n < 40);
    if (!oTICK) chk("tickTimeout", 0, 1);
  endtask

  initial begin
    iRST_N = 1'b0;
    iDATA  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      iDATA = ~iDATA;
    end
    chk("rstOutputs", int'({oLOCK, oMATCH, oTICK, oFRAMES, oERR}), 0);

    // idle line: free-running ticks only
    @(negedge iCLK);
    iDATA  = 1'b0;
    iRST_N = 1'b1;
    t0 = tickCnt;
    repeat (160) @(negedge iCLK);
    chk("idleTicks", tickCnt - t0, 20);
    chk("idleGap", tickGap, 8);
    chk("idleLock", oLOCK, 0);
    chk("idleMatch", matchCnt, 0);
    chk("idleFrames", oFRAMES, 0);
    chk("idleErr", oERR, 0);

    // lock on the 12th step
    waitTick();
    sendBits(PAT, 0, 10, 8);
    chk("preLock", oLOCK, 0);
    sendBits(PAT, 11, 11, 8);
    chk("lock", oLOCK, 1);
    chk("lockMatch", matchCnt, 1);
    chk("lockFrames", oFRAMES, 1);
    sendBits(PAT, 0, 11, 8);
    chk("gap2", matchGap, 96);
    sendBits(PAT, 0, 11, 8);
    chk("gap3", matchGap, 96);
    chk("frames3", oFRAMES, 3);
    chk("err3", oERR, 0);

    // +-2 cycle step jitter
    sendJit(PAT);
    sendJit(PAT);
    chk("jitLock", oLOCK, 1);
    chk("jitFrames", oFRAMES, 5);
    chk("jitErr", oERR, 0);

    // loss and re-lock
    sendBits(BAD, 0, 11, 8);
    chk("bad1Err", oERR, 1);
    chk("bad1Lock", oLOCK, 1);
    sendBits(BAD, 0, 11, 8);
    chk("bad2Err", oERR, 2);
    chk("bad2Lock", oLOCK, 0);
    chk("bad2Frames", oFRAMES, 5);
    sendBits(PAT, 0, 11, 8);
    chk("relock", oLOCK, 1);
    chk("relockFrames", oFRAMES, 6);

    // saturation
    m0 = matchCnt;
    for (int f = 0; f < 300; f++) sendBits(PAT, 0, 11, 8);
    chk("satFrames", oFRAMES, 255);
    chk("satMatches", matchCnt - m0, 300);
    chk("satErr", oERR, 2);
    chk("satLock", oLOCK, 1);

    // async reset at step 7 of a locked frame
    sendBits(PAT, 0, 6, 8);
    iDATA = PAT[4];
    #2;
    iRST_N = 1'b0;
    #1;
    chk("asyncRst", int'({oLOCK, oMATCH, oTICK, oFRAMES, oERR}), 0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    m0 = matchCnt;
    waitTick();
    sendBits(PAT, 7, 11, 8);
    chk("partialLock", oLOCK, 0);
    chk("partialMatch", matchCnt - m0, 0);
    sendBits(PAT, 0, 11, 8);
    chk("postRstLock", oLOCK, 1);
    chk("postRstFrames", oFRAMES, 1);
    chk("postRstMatch", matchCnt - m0, 1);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule

// File: doc/wzorzec_detektor.md
Name: wzorzec_detektor

Overview:
- Downstream consumer of the LED pattern generator's serial output: samples the 1-bit blink stream once per pattern step, recovers step timing from signal edges, and checks that the 12-step pattern repeats correctly.
- Provides a lock flag, a per-frame match pulse, and saturating good/bad frame counters for LEDs or a display stage.

Parameters:
- STEP_CYCLES, 5000000, iCLK cycles per pattern step (100 ms at 50 MHz); must be even and >= 4.
- LEN, 12, pattern length in steps.
- PATTERN, 12'hE64, expected sequence, MSB sent first (1,1,1,0,0,1,1,0,0,1,0,0).
- MISS_MAX, 3, consecutive bad frames in LOCKED before returning to HUNT.

Ports:
- iCLK  input  1  system clock.
- iRST_N  input  1  asynchronous, active-low reset.
- iDATA  input  1  serial pattern stream (the generator's LED output); asynchronous to the step grid.
- oLOCK  output  1  high while in LOCKED.
- oMATCH  output  1  one-cycle pulse per correctly received frame.
- oTICK  output  1  one-cycle pulse on each sample instant (debug).
- oFRAMES  output  8  good-frame count, saturates at 255.
- oERR  output  8  bad-frame count in LOCKED, saturates at 255.

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchroniser 0; shift register 0; fill, bit and miss counters 0; phase counter 0; state HUNT. Reset mid-frame discards all progress.
- Input synchroniser: 2 flops (s1, s2), plus a third flop s3 for edge detection. edge = s2 XOR s3.
- Phase counter (0..STEP_CYCLES-1):
  - tick = (counter == STEP_CYCLES/2-1), evaluated on the pre-update value.
  - Next counter value: 0 if edge (priority); else 0 if at STEP_CYCLES-1; else +1.
  - Edge and tick in the same cycle: the tick still fires and the counter still loads 0.
  - Net effect: sampling lands mid-step, STEP_CYCLES/2 cycles after the last synchronised edge.
- oTICK is the registered tick (1 cycle late).
- On tick: sample = s2; shift <= {shift[LEN-2:0], sample}; fill counter increments, saturating at LEN. Comparisons below use the new shift value.
- HUNT:
  - On tick with fill == LEN (including the tick that makes it LEN) and new shift == PATTERN: go to LOCKED, bit counter = 0, miss counter = 0, pulse oMATCH, increment oFRAMES.
  - Any other tick: stay in HUNT. No error counting in HUNT.
- LOCKED:
  - On tick: bit counter increments, wrapping LEN-1 -> 0.
  - On the tick where the bit counter wraps to 0 (every LEN ticks after lock):
    - Match: pulse oMATCH, increment oFRAMES, clear miss counter.
    - Mismatch: increment oERR and miss counter. If miss reaches MISS_MAX: go to HUNT, clear miss counter; shift and fill are retained, so an immediate re-lock on the next tick is allowed.
- oLOCK, oMATCH, oFRAMES and oERR all update on the clock edge after the tick cycle, i.e. the same cycle as oTICK.
- Counters saturate at 255 and never wrap. oMATCH still pulses when oFRAMES is saturated.
- Constant iDATA (stuck line): no edges, so the free-running phase counter keeps ticking every STEP_CYCLES cycles. A stuck-at-0 or stuck-at-1 frame mismatches and, after MISS_MAX frames, returns to HUNT.

Test Plan:
- All tests use STEP_CYCLES=8, MISS_MAX=2.
- Reset: hold iRST_N=0 with iDATA toggling -> all outputs 0. Release and drive iDATA=0 for 20 steps -> oTICK every 8 cycles; oLOCK, oMATCH and counters stay 0.
- Lock: drive PATTERN step-aligned (8 cycles/bit) from reset -> on the 12th tick oLOCK=1 and oMATCH pulses, oFRAMES=1. Two more frames -> oFRAMES=3, oERR=0, oMATCH spaced exactly 96 cycles.
- Jitter: same stream, but each step lengthened or shortened by ±2 cycles -> lock retained, no oERR increment (mid-step resync).
- Loss: after lock, send two frames with bit 5 inverted -> oERR=1 then 2; oLOCK falls with the second. A correct frame follows -> re-lock, oFRAMES increments.
- Saturation: 300 good frames -> oFRAMES=255, oMATCH still pulses each frame.
- Async reset mid-frame at bit 7 in LOCKED -> outputs 0 immediately, without waiting for iCLK. After release a full 12-bit frame is required before oMATCH.
